// File: rtl/ps2_cmd_arbiter.sv
// Arbitrates two command requesters onto one PS/2 transceiver: sends the granted
// byte, waits for the mouse ACK, retries on resend/corruption/timeout, reports DONE/ERR.
module ps2_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  input  logic [7:0] REQ0_BYTE,
  output logic       REQ0_DONE,
  output logic       REQ0_ERR,
  input  logic       REQ1_VALID,
  input  logic [7:0] REQ1_BYTE,
  output logic       REQ1_DONE,
  output logic       REQ1_ERR,
  output logic [7:0] RESP_BYTE,
  output logic       BUSY,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY
);

  localparam int unsigned       RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_ACK,
    S_RETRY,
    S_FINISH
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] timer;
  logic [RW-1:0]    retry;
  logic             owner, last_grant, ok;
  logic             grant, grant_port, ok_nx, load_resp, timeout;

  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    ok_nx      = ok;
    load_resp  = 1'b0;
    timeout    = (timer == TMO_LAST);
    case (state)
      S_IDLE: begin
        if (REQ0_VALID && REQ1_VALID) begin
          grant      = 1'b1;
          grant_port = ~last_grant;
        end else if (REQ0_VALID) begin
          grant      = 1'b1;
          grant_port = 1'b0;
        end else if (REQ1_VALID) begin
          grant      = 1'b1;
          grant_port = 1'b1;
        end
        if (grant) state_nx = S_SEND;
      end
      S_SEND: state_nx = S_WAIT_SENT;
      S_WAIT_SENT: begin
        if (BYTE_SENT)    state_nx = S_WAIT_ACK;
        else if (timeout) state_nx = S_RETRY;
      end
      S_WAIT_ACK: begin
        // A received byte takes priority over a coincident timeout.
        if (BYTE_READY) begin
          load_resp = 1'b1;
          if (BYTE_ERROR_CODE != 2'b00) begin
            state_nx = S_RETRY;
          end else if (BYTE_READ == 8'hFA) begin
            state_nx = S_FINISH;
            ok_nx    = 1'b1;
          end else if (BYTE_READ == 8'hFE) begin
            state_nx = S_RETRY;
          end else begin
            state_nx = S_FINISH;
            ok_nx    = 1'b0;
          end
        end else if (timeout) begin
          state_nx = S_RETRY;
        end
      end
      S_RETRY: begin
        if (retry < RETRY_MAX) begin
          state_nx = S_SEND;
        end else begin
          state_nx = S_FINISH;
          ok_nx    = 1'b0;
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from state_nx so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      timer        <= '0;
      retry        <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      ok           <= 1'b0;
      REQ0_DONE    <= 1'b0;
      REQ0_ERR     <= 1'b0;
      REQ1_DONE    <= 1'b0;
      REQ1_ERR     <= 1'b0;
      RESP_BYTE    <= '0;
      BUSY         <= 1'b0;
      SEND_BYTE    <= 1'b0;
      BYTE_TO_SEND <= '0;
      READ_ENABLE  <= 1'b0;
    end else begin
      state <= state_nx;
      ok    <= ok_nx;
      if (state_nx != state) timer <= '0;
      else if (timer != '1)  timer <= timer + 1'b1;
      if (grant) begin
        owner        <= grant_port;
        last_grant   <= grant_port;
        retry        <= '0;
        BYTE_TO_SEND <= grant_port ? REQ1_BYTE : REQ0_BYTE;
      end else if (state == S_RETRY && state_nx == S_SEND) begin
        retry <= retry + 1'b1;
      end
      if (load_resp) RESP_BYTE <= BYTE_READ;
      SEND_BYTE   <= (state == S_SEND);
      READ_ENABLE <= (state_nx == S_WAIT_ACK);
      BUSY        <= (state_nx != S_IDLE);
      REQ0_DONE   <= (state_nx == S_FINISH) &&  ok_nx && !owner;
      REQ0_ERR    <= (state_nx == S_FINISH) && !ok_nx && !owner;
      REQ1_DONE   <= (state_nx == S_FINISH) &&  ok_nx &&  owner;
      REQ1_ERR    <= (state_nx == S_FINISH) && !ok_nx &&  owner;
    end
  end

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Directed bench for ps2_cmd_arbiter: scripted mouse responder plus a scoreboard
// of expected transmitter sends and DONE/ERR pulses.
module tb_ps2_cmd_arbiter;

  localparam int unsigned K_SEND  = 0;
  localparam int unsigned K_DONE0 = 1;
  localparam int unsigned K_ERR0  = 2;
  localparam int unsigned K_DONE1 = 3;
  localparam int unsigned K_ERR1  = 4;

  logic       CLK, RESET;
  logic       REQ0_VALID, REQ0_DONE, REQ0_ERR;
  logic       REQ1_VALID, REQ1_DONE, REQ1_ERR;
  logic [7:0] REQ0_BYTE, REQ1_BYTE, RESP_BYTE, BYTE_TO_SEND, BYTE_READ;
  logic       BUSY, SEND_BYTE, BYTE_SENT, READ_ENABLE, BYTE_READY;
  logic [1:0] BYTE_ERROR_CODE;

  typedef struct {
    int unsigned kind;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic       do_ack;
    logic [7:0] b;
    logic [1:0] e;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ps2_cmd_arbiter #(
    .TIMEOUT_CYCLES(100),
    .MAX_RETRY(3),
    .CNT_W(20)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_BYTE(REQ0_BYTE), .REQ0_DONE(REQ0_DONE), .REQ0_ERR(REQ0_ERR),
    .REQ1_VALID(REQ1_VALID), .REQ1_BYTE(REQ1_BYTE), .REQ1_DONE(REQ1_DONE), .REQ1_ERR(REQ1_ERR),
    .RESP_BYTE(RESP_BYTE), .BUSY(BUSY), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .BYTE_SENT(BYTE_SENT), .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe(input int unsigned kind, input logic [7:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", kind, 32'hFFFF);
    end else begin
      e = exp_q.pop_front();
      check("sb_event_kind", kind, e.kind);
      if (e.kind == K_SEND && kind == K_SEND) check("sb_send_byte", {24'h0, d}, {24'h0, e.data});
    end
  endtask

  // Scoreboard monitor: every send and completion pulse pops one expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (SEND_BYTE) observe(K_SEND, BYTE_TO_SEND);
      if (REQ0_DONE) observe(K_DONE0, 8'h00);
      if (REQ0_ERR)  observe(K_ERR0, 8'h00);
      if (REQ1_DONE) observe(K_DONE1, 8'h00);
      if (REQ1_ERR)  observe(K_ERR1, 8'h00);
    end
  end

  // Mouse/transceiver model: one scripted reply per transmitted byte; none means silence.
  initial begin
    rsp_t r;
    BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_READ = '0; BYTE_ERROR_CODE = '0;
    forever begin
      @(negedge CLK);
      if (SEND_BYTE && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        repeat (2) @(negedge CLK);
        BYTE_SENT = 1'b1;
        @(negedge CLK);
        BYTE_SENT = 1'b0;
        if (r.do_ack) begin
          for (int i = 0; i < 50 && !READ_ENABLE; i++) @(negedge CLK);
          @(negedge CLK);
          BYTE_READ = r.b; BYTE_ERROR_CODE = r.e; BYTE_READY = 1'b1;
          @(negedge CLK);
          BYTE_READY = 1'b0; BYTE_ERROR_CODE = '0;
        end
      end
    end
  end

  task automatic push_cmd(input logic port, input logic [7:0] b, input int unsigned sends,
                          input logic ok);
    for (int unsigned i = 0; i < sends; i++) exp_q.push_back('{K_SEND, b});
    if (!port) exp_q.push_back('{ok ? K_DONE0 : K_ERR0, 8'h00});
    else       exp_q.push_back('{ok ? K_DONE1 : K_ERR1, 8'h00});
  endtask

  task automatic rsp(input logic do_ack, input logic [7:0] b, input logic [1:0] e);
    rsp_q.push_back('{do_ack, b, e});
  endtask

  // Plays both requesters: drops VALID on seeing its DONE/ERR, returns once idle.
  task automatic run_until_idle(input int unsigned budget, input string tag);
    int unsigned n = 0;
    do begin
      @(negedge CLK);
      if (REQ0_DONE || REQ0_ERR) REQ0_VALID = 1'b0;
      if (REQ1_DONE || REQ1_ERR) REQ1_VALID = 1'b0;
      n++;
    end while ((REQ0_VALID || REQ1_VALID || BUSY) && n < budget);
    check({tag, "_complete"}, {31'h0, REQ0_VALID | REQ1_VALID | BUSY}, 32'h0);
    check({tag, "_sb_drained"}, exp_q.size(), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_send_byte"},   {31'h0, SEND_BYTE},   32'h0);
    check({tag, "_read_enable"}, {31'h0, READ_ENABLE}, 32'h0);
    check({tag, "_busy"},        {31'h0, BUSY},        32'h0);
    check({tag, "_done_err"},    {28'h0, REQ0_DONE, REQ0_ERR, REQ1_DONE, REQ1_ERR}, 32'h0);
    check({tag, "_resp_byte"},   {24'h0, RESP_BYTE},   32'h0);
    check({tag, "_byte_to_send"}, {24'h0, BYTE_TO_SEND}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    int unsigned n;
    RESET = 1'b1;
    REQ0_VALID = 1'b0; REQ0_BYTE = '0; REQ1_VALID = 1'b0; REQ1_BYTE = '0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RESET = 1'b0;
    @(negedge CLK);

    // Single command, ACKed: latency and response capture.
    push_cmd(1'b0, 8'hF4, 1, 1'b1);
    rsp(1'b1, 8'hFA, 2'b00);
    REQ0_BYTE = 8'hF4; REQ0_VALID = 1'b1;
    @(negedge CLK);
    check("t1_send_lat1", {31'h0, SEND_BYTE}, 32'h0);
    @(negedge CLK);
    check("t1_send_lat2", {31'h0, SEND_BYTE}, 32'h1);
    run_until_idle(200, "t1");
    check("t1_resp_byte", {24'h0, RESP_BYTE}, 32'hFA);
    @(negedge CLK);
    check("t1_busy_after", {31'h0, BUSY}, 32'h0);

    // Tie right after reset: port 0 first; after a solo port 0 command, a tie favours port 1.
    do_reset();
    push_cmd(1'b0, 8'hF3, 1, 1'b1);
    push_cmd(1'b1, 8'hE8, 1, 1'b1);
    rsp(1'b1, 8'hFA, 2'b00); rsp(1'b1, 8'hFA, 2'b00);
    REQ0_BYTE = 8'hF3; REQ1_BYTE = 8'hE8; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    run_until_idle(400, "t2_tie_a");
    push_cmd(1'b0, 8'hEA, 1, 1'b1);
    rsp(1'b1, 8'hFA, 2'b00);
    REQ0_BYTE = 8'hEA; REQ0_VALID = 1'b1;
    run_until_idle(200, "t2_solo");
    push_cmd(1'b1, 8'hE8, 1, 1'b1);
    push_cmd(1'b0, 8'hF3, 1, 1'b1);
    rsp(1'b1, 8'hFA, 2'b00); rsp(1'b1, 8'hFA, 2'b00);
    REQ0_BYTE = 8'hF3; REQ1_BYTE = 8'hE8; REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    run_until_idle(400, "t2_tie_b");

    // Two resend requests then ACK.
    push_cmd(1'b1, 8'hC8, 3, 1'b1);
    rsp(1'b1, 8'hFE, 2'b00); rsp(1'b1, 8'hFE, 2'b00); rsp(1'b1, 8'hFA, 2'b00);
    REQ1_BYTE = 8'hC8; REQ1_VALID = 1'b1;
    run_until_idle(400, "t3");
    check("t3_resp_byte", {24'h0, RESP_BYTE}, 32'hFA);

    // Silent device: every attempt times out, four transmissions then ERR.
    push_cmd(1'b0, 8'hFF, 4, 1'b0);
    REQ0_BYTE = 8'hFF; REQ0_VALID = 1'b1;
    run_until_idle(1000, "t4");

    // Non-ACK reply fails without retry; corrupted ACK is resent.
    push_cmd(1'b1, 8'hF2, 1, 1'b0);
    rsp(1'b1, 8'hFC, 2'b00);
    REQ1_BYTE = 8'hF2; REQ1_VALID = 1'b1;
    run_until_idle(200, "t5_fc");
    check("t5_resp_fc", {24'h0, RESP_BYTE}, 32'hFC);
    push_cmd(1'b0, 8'hF3, 2, 1'b1);
    rsp(1'b1, 8'hFA, 2'b01); rsp(1'b1, 8'hFA, 2'b00);
    REQ0_BYTE = 8'hF3; REQ0_VALID = 1'b1;
    run_until_idle(300, "t5_err_code");
    check("t5_resp_fa", {24'h0, RESP_BYTE}, 32'hFA);

    // Reset while waiting for the ACK aborts silently.
    exp_q.push_back('{K_SEND, 8'hF4});
    rsp(1'b0, 8'h00, 2'b00);
    REQ0_BYTE = 8'hF4; REQ0_VALID = 1'b1;
    n = 0;
    while (!READ_ENABLE && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("t6_reached_wait_ack", {31'h0, READ_ENABLE}, 32'h1);
    RESET = 1'b1; REQ0_VALID = 1'b0;
    @(negedge CLK);
    check_all_zero("t6_abort");
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    check("t6_sb_after_abort", exp_q.size(), 32'h0);
    push_cmd(1'b0, 8'hF4, 1, 1'b1);
    rsp(1'b1, 8'hFA, 2'b00);
    REQ0_VALID = 1'b1;
    run_until_idle(200, "t6_after");

    repeat (5) @(negedge CLK);
    check("final_sb_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
